// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - CPU-side INTA_ acknowledge sequencer for a pic8259 (8086 mode)
//
// Synchronises the PIC INT request, issues the two-pulse INTA_ acknowledge,
// captures the vector byte driven during the second pulse and hands it to
// the CPU through a valid/ack handshake.
//
// Ports:
//   CLK          system clock, rising edge
//   RST_         asynchronous active-low reset
//   INT          interrupt request from the PIC (asynchronous)
//   int_en       CPU interrupt enable; gates the start of a sequence
//   data_bus     PIC data bus, sampled at the end of the second pulse
//   vec_ack      CPU consumes the captured vector (seen only in DONE)
//   INTA_        active-low interrupt acknowledge to the PIC
//   vector       last captured vector
//   vector_valid vector holds an unconsumed value
//   busy         sequencer is not idle
//   int_count    completed acknowledge sequences, wraps at 256
module pic_inta_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_W     = 2,
    parameter int GAP_W       = 2,
    parameter int RECOV_W     = 3
) (
    input  logic       CLK,
    input  logic       RST_,
    input  logic       INT,
    input  logic       int_en,
    input  logic [7:0] data_bus,
    input  logic       vec_ack,
    output logic       INTA_,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy,
    output logic [7:0] int_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK1,
        S_GAP,
        S_ACK2,
        S_DONE,
        S_RECOVER
    } state_t;

    localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);
    localparam logic [3:0] RECOV_LD = 4'(RECOV_W - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   int_s;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       inta_d;
    logic [7:0] vector_d;
    logic       valid_d;
    logic [7:0] count_d;
    logic       busy_d;

    assign int_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= INT;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            INTA_        <= 1'b1;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
            int_count    <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            INTA_        <= inta_d;
            vector       <= vector_d;
            vector_valid <= valid_d;
            busy         <= busy_d;
            int_count    <= count_d;
        end
    end

    // Outputs are computed as next-state values so every output is a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_d   = INTA_;
        vector_d = vector;
        valid_d  = vector_valid;
        count_d  = int_count;

        case (state_q)
            S_IDLE: begin
                if (int_s && int_en) begin
                    state_d = S_ACK1;
                    inta_d  = 1'b0;
                    cnt_d   = PULSE_LD;
                end
            end
            S_ACK1: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_GAP;
                    inta_d  = 1'b1;
                    cnt_d   = GAP_LD;
                end
            end
            S_GAP: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_ACK2;
                    inta_d  = 1'b0;
                    cnt_d   = PULSE_LD;
                end
            end
            S_ACK2: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Capture on the edge that ends the pulse, while the PIC
                    // is still driving the bus.
                    state_d  = S_DONE;
                    inta_d   = 1'b1;
                    vector_d = data_bus;
                    valid_d  = 1'b1;
                    count_d  = int_count + 8'd1;
                end
            end
            S_DONE: begin
                if (vec_ack) begin
                    state_d = S_RECOVER;
                    valid_d = 1'b0;
                    cnt_d   = RECOV_LD;
                end
            end
            S_RECOVER: begin
                // Lets the stale synchronised INT drain before IDLE looks at it.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                inta_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - scoreboard bench for pic_inta_sequencer
`timescale 1ns/1ps
module tb_pic_inta_sequencer;

    localparam int RECOV = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n   = 1'b0;
    logic       int_req = 1'b0;
    logic       int_en  = 1'b0;
    logic       vec_ack = 1'b0;
    logic       sel     = 1'b0;
    logic [7:0] data_bus;

    logic       inta0, valid0, busy0, inta1, valid1, busy1;
    logic [7:0] vec0, cnt0, vec1, cnt1;
    logic       en0, en1;

    assign en0 = int_en & ~sel;
    assign en1 = int_en & sel;

    pic_inta_sequencer #(.SYNC_STAGES(2), .PULSE_W(2), .GAP_W(2), .RECOV_W(3)) u_dut0 (
        .CLK(clk), .RST_(rst_n), .INT(int_req), .int_en(en0), .data_bus(data_bus),
        .vec_ack(vec_ack), .INTA_(inta0), .vector(vec0), .vector_valid(valid0),
        .busy(busy0), .int_count(cnt0)
    );

    pic_inta_sequencer #(.SYNC_STAGES(2), .PULSE_W(1), .GAP_W(1), .RECOV_W(3)) u_dut1 (
        .CLK(clk), .RST_(rst_n), .INT(int_req), .int_en(en1), .data_bus(data_bus),
        .vec_ack(vec_ack), .INTA_(inta1), .vector(vec1), .vector_valid(valid1),
        .busy(busy1), .int_count(cnt1)
    );

    logic       mon_inta, mon_valid, mon_busy;
    logic [7:0] mon_vector, mon_count;
    assign mon_inta   = sel ? inta1  : inta0;
    assign mon_valid  = sel ? valid1 : valid0;
    assign mon_busy   = sel ? busy1  : busy0;
    assign mon_vector = sel ? vec1   : vec0;
    assign mon_count  = sel ? cnt1   : cnt0;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: expected {vector, int_count} per sequence.
    int          cnt_model [2] = '{0, 0};
    logic [15:0] sb_q [$];
    logic [7:0]  pic_base  = 8'h98;
    logic [2:0]  pic_level = 3'd0;
    logic [7:0]  last_vec  = 8'h00;

    // PIC model: drives the vector only while the second INTA_ pulse is low.
    int         pulse_no  = 0;
    logic [7:0] drive_vec = 8'h00;
    logic [7:0] junk      = 8'h00;

    always @(negedge mon_inta or negedge rst_n) begin
        if (!rst_n) begin
            pulse_no = 0;
        end else begin
            pulse_no = (pulse_no == 1) ? 2 : 1;
            if (pulse_no == 2)
                drive_vec = int_req ? (pic_base | {5'd0, pic_level}) : (pic_base | 8'd7);
        end
    end

    always @(negedge clk) junk = 8'($urandom);

    assign data_bus = (!mon_inta && pulse_no == 2) ? drive_vec : junk;

    // Monitor: pulse timing and scoreboard pops, sampled on the falling edge.
    int          low_len = 0, high_len = 0, pulses = 0;
    logic        prev_inta = 1'b1, prev_valid = 1'b0;
    logic [15:0] sb_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            low_len = 0; high_len = 0; pulses = 0;
            prev_inta = 1'b1; prev_valid = 1'b0;
        end else begin
            if (!mon_inta) begin
                if (prev_inta && pulses == 1)
                    check("gap_width", high_len, sel ? 1 : 2);
                low_len++;
            end else begin
                if (!prev_inta) begin
                    check("pulse_width", low_len, sel ? 1 : 2);
                    pulses++;
                    low_len = 0;
                end
                high_len = prev_inta ? high_len + 1 : 1;
            end
            if (mon_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_vector", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_vector", mon_vector, sb_e[15:8]);
                    check("sb_count", mon_count, sb_e[7:0]);
                end
                check("two_pulses", pulses, 2);
                pulses = 0;
            end
            if (mon_valid)
                check("inta_high_in_done", mon_inta, 1);
            prev_inta  = mon_inta;
            prev_valid = mon_valid;
        end
    end

    task automatic prime(input logic [7:0] base, input logic [2:0] level, input bit withdraw);
        logic [7:0] e;
        pic_base  = base & 8'hF8;
        pic_level = level;
        e = withdraw ? (pic_base | 8'd7) : (pic_base | {5'd0, level});
        cnt_model[sel] = (cnt_model[sel] + 1) % 256;
        sb_q.push_back({e, 8'(cnt_model[sel])});
        last_vec = e;
    endtask

    task automatic start_seq();
        int n = 0;
        int_req = 1'b1;
        int_en  = 1'b1;
        while (mon_inta && n < 20) begin @(posedge clk); #1; n++; end
        check("start_inta_low", mon_inta, 0);
        check("start_busy", mon_busy, 1);
    endtask

    task automatic finish_seq(input bit withdraw, input bit keep_int, input int ack_delay);
        int n = 0;
        if (withdraw) begin
            while (!mon_inta && n < 20) begin @(posedge clk); #1; n++; end
            int_req = 1'b0;
        end
        n = 0;
        while (!mon_valid && n < 40) begin
            vec_ack = 1'($urandom);
            @(posedge clk); #1; n++;
        end
        vec_ack = 1'b0;
        check("valid_rise", mon_valid, 1);
        if (!keep_int) int_req = 1'b0;
        @(posedge clk); #1;
        check("valid_hold_after_early_ack", mon_valid, 1);
        repeat (ack_delay) begin @(posedge clk); #1; check("valid_hold", mon_valid, 1); end
        vec_ack = 1'b1;
        @(posedge clk); #1;
        vec_ack = 1'b0;
        check("valid_clear", mon_valid, 0);
        check("vector_kept", mon_vector, last_vec);
        check("busy_recover", mon_busy, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        int_req = 1'b0;
        int_en  = 1'b0;
        while (mon_busy && n < 30) begin @(posedge clk); #1; n++; end
        check("return_idle", mon_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit w;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inta", mon_inta, 1);
        check("rst_valid", mon_valid, 0);
        check("rst_busy", mon_busy, 0);
        check("rst_count", mon_count, 0);
        check("rst_vector", mon_vector, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic: ICW2=0x98, IR3 -> 0x9B
        prime(8'h98, 3'd3, 1'b0);
        start_seq();
        finish_seq(1'b0, 1'b0, 0);
        check("basic_count", mon_count, 1);
        wait_idle();

        // Asynchronous reset in the middle of ACK1
        prime(8'($urandom), 3'($urandom), 1'b0);
        start_seq();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_inta", mon_inta, 1);
        check("midrst_busy", mon_busy, 0);
        check("midrst_valid", mon_valid, 0);
        check("midrst_count", mon_count, 0);
        check("midrst_vector", mon_vector, 0);
        int_req = 1'b0;
        int_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("heldrst_inta", mon_inta, 1);
        check("heldrst_busy", mon_busy, 0);
        sb_q.delete();
        cnt_model[0] = 0;
        cnt_model[1] = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Masked request
        int_req = 1'b1;
        int_en  = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            check("masked_inta", mon_inta, 1);
            check("masked_busy", mon_busy, 0);
        end
        prime(8'($urandom), 3'($urandom), 1'b0);
        int_en = 1'b1;
        @(posedge clk); #1;
        check("unmask_latency", mon_inta, 0);
        finish_seq(1'b0, 1'b0, 0);
        wait_idle();

        // Request withdrawn during GAP -> IR7 spurious vector 0x9F
        prime(8'h98, 3'd2, 1'b1);
        start_seq();
        finish_seq(1'b1, 1'b0, 0);
        check("withdraw_vector", mon_vector, 8'h9F);
        wait_idle();

        // Handshake hold and recovery spacing with INT held high
        prime(8'($urandom), 3'($urandom), 1'b0);
        start_seq();
        finish_seq(1'b0, 1'b1, 10);
        n = 0;
        while (mon_inta && n < 20) begin @(posedge clk); #1; n++; end
        check("ack_to_next_ack1", n, RECOV + 1);
        prime(8'($urandom), 3'($urandom), 1'b0);
        finish_seq(1'b0, 1'b0, 0);
        wait_idle();

        // Random sequences until the completion counter wraps to zero
        n = 0;
        while (cnt_model[0] != 0 && n < 300) begin
            w = 1'($urandom);
            prime(8'($urandom), 3'($urandom), w);
            start_seq();
            finish_seq(w, 1'b0, $urandom_range(0, 3));
            n++;
        end
        wait_idle();
        check("wrap_count", mon_count, 8'h00);

        // Single-cycle pulses and gap on the second instance
        sel = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            w = 1'($urandom);
            prime(8'($urandom), 3'($urandom), w);
            start_seq();
            finish_seq(w, 1'b0, $urandom_range(0, 2));
        end
        wait_idle();
        check("fast_count", mon_count, 8);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
